// File: rtl/alu_pkg.sv
// Shared types and constants for the EX-stage ALU.
//   alu_op_e   : 4-bit opcode encoding (13 defined ops; 13..15 yield zero)
//   alu_pair_t : {hi, lo} result pair returned by the multiply/divide unit
//   add_ovf / sub_ovf : signed-overflow predicates on operand/result sign bits
package alu_pkg;

    localparam int unsigned ALU_W   = 32;
    localparam int unsigned SHAMT_W = 5;
    localparam int unsigned OP_W    = 4;

    typedef enum logic [OP_W-1:0] {
        SLL  = 4'd0,
        SRA  = 4'd1,
        SRL  = 4'd2,
        MUL  = 4'd3,
        DIV  = 4'd4,
        ADD  = 4'd5,
        SUB  = 4'd6,
        AND  = 4'd7,
        OR   = 4'd8,
        XOR  = 4'd9,
        NOR  = 4'd10,
        SLT  = 4'd11,
        SLTU = 4'd12
    } alu_op_e;

    // hi: multiply high word / divide remainder; lo: multiply low word / quotient
    typedef struct packed {
        logic [ALU_W-1:0] hi;
        logic [ALU_W-1:0] lo;
    } alu_pair_t;

    // Same-sign operands whose sum flips sign
    function automatic logic add_ovf(input logic a_s, input logic b_s, input logic r_s);
        return (a_s == b_s) && (r_s != a_s);
    endfunction

    // Opposite-sign operands whose difference leaves the sign of the minuend
    function automatic logic sub_ovf(input logic a_s, input logic b_s, input logic r_s);
        return (a_s != b_s) && (r_s != a_s);
    endfunction

endpackage

// File: rtl/alu_muldiv.sv
// Combinational signed multiply / divide unit.
// Only instantiated when ALU_MULDIV_EN is defined.
// Ports:
//   x, y   : signed operands (dividend / divisor for divide)
//   is_div : 1 selects divide, 0 selects multiply
//   res    : multiply -> {high word, low word}; divide -> {remainder, quotient}
module alu_muldiv
    import alu_pkg::*;
(
    input  logic [ALU_W-1:0] x,
    input  logic [ALU_W-1:0] y,
    input  logic             is_div,
    output alu_pair_t        res
);

    localparam logic [ALU_W-1:0] MIN_INT = {1'b1, {(ALU_W-1){1'b0}}};

    logic signed [2*ALU_W-1:0] prod;
    logic                      div_by_zero;
    logic                      div_ovf;
    logic        [ALU_W-1:0]   safe_y;
    logic signed [ALU_W-1:0]   quo;
    logic signed [ALU_W-1:0]   rem;

    // Full-width signed product, signed quotient/remainder, result select
    always_comb begin
        prod        = (2*ALU_W)'($signed(x)) * (2*ALU_W)'($signed(y));
        div_by_zero = (y == '0);
        div_ovf     = (x == MIN_INT) && (y == '1);
        // Substituting a divisor of 1 keeps the divider away from the two
        // undefined cases; MIN_INT / 1 also yields the required MIN_INT, 0.
        safe_y      = (div_by_zero || div_ovf) ? ALU_W'(1) : y;
        quo         = $signed(x) / $signed(safe_y);
        rem         = $signed(x) % $signed(safe_y);

        res = '0;
        if (is_div) begin
            if (div_by_zero) begin
                res.lo = '1;
                res.hi = x;
            end else begin
                res.lo = quo;
                res.hi = rem;
            end
        end else begin
            res.lo = prod[ALU_W-1:0];
            res.hi = prod[2*ALU_W-1:ALU_W];
        end
    end

endmodule

// File: rtl/alu.sv
// 32-bit EX-stage integer ALU with one cycle of registered latency.
// Optional feature macro: ALU_MULDIV_EN builds the signed multiplier/divider
// (ops MUL/DIV); without it those ops produce all-zero outputs.
// Ports:
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   x, y     : operands (y is also the shift source)
//   alu_op   : operation select (alu_op_e; 13..15 give zero results)
//   shamt    : shift amount
//   result1  : primary result
//   result2  : multiply high word / divide remainder, otherwise 0
//   of, uof  : signed overflow and unsigned carry/borrow (ADD/SUB only)
//   equal    : x == y, for every opcode
module alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    input  logic [OP_W-1:0]    alu_op,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [WIDTH-1:0]   result1,
    output logic [WIDTH-1:0]   result2,
    output logic               of,
    output logic               uof,
    output logic               equal
);

    logic [WIDTH:0]   add_full;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] result1_c;
    logic [WIDTH-1:0] result2_c;
    logic             of_c;
    logic             uof_c;
    logic             equal_c;

`ifdef ALU_MULDIV_EN
    alu_pair_t md_res;

    alu_muldiv u_muldiv (
        .x      (x),
        .y      (y),
        .is_div (alu_op == DIV),
        .res    (md_res)
    );
`endif

    // Opcode decode and result mux
    always_comb begin
        add_full  = {1'b0, x} + {1'b0, y};
        diff      = x - y;
        result1_c = '0;
        result2_c = '0;
        of_c      = 1'b0;
        uof_c     = 1'b0;
        equal_c   = (x == y);

        case (alu_op)
            SLL:  result1_c = y << shamt;
            SRA:  result1_c = $signed(y) >>> shamt;
            SRL:  result1_c = y >> shamt;
`ifdef ALU_MULDIV_EN
            MUL, DIV: begin
                result1_c = md_res.lo;
                result2_c = md_res.hi;
            end
`endif
            ADD: begin
                result1_c = add_full[WIDTH-1:0];
                uof_c     = add_full[WIDTH];
                of_c      = add_ovf(x[WIDTH-1], y[WIDTH-1], add_full[WIDTH-1]);
            end
            SUB: begin
                result1_c = diff;
                uof_c     = (x < y);
                of_c      = sub_ovf(x[WIDTH-1], y[WIDTH-1], diff[WIDTH-1]);
            end
            AND:  result1_c = x & y;
            OR:   result1_c = x | y;
            XOR:  result1_c = x ^ y;
            NOR:  result1_c = ~(x | y);
            SLT:  result1_c = WIDTH'($signed(x) < $signed(y));
            SLTU: result1_c = WIDTH'(x < y);
            default: ;
        endcase
    end

    // Output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result1 <= '0;
            result2 <= '0;
            of      <= 1'b0;
            uof     <= 1'b0;
            equal   <= 1'b0;
        end else begin
            result1 <= result1_c;
            result2 <= result2_c;
            of      <= of_c;
            uof     <= uof_c;
            equal   <= equal_c;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed plan vectors against constants,
// reset behaviour, then randomized vectors against an arithmetic model.
module tb_alu;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] x;
    logic [31:0] y;
    logic [3:0]  alu_op;
    logic [4:0]  shamt;
    logic [31:0] result1;
    logic [31:0] result2;
    logic        of;
    logic        uof;
    logic        equal;

    int vectors     = 0;
    int miscompares = 0;

    alu dut (
        .clk     (clk),
        .rst     (rst),
        .x       (x),
        .y       (y),
        .alu_op  (alu_op),
        .shamt   (shamt),
        .result1 (result1),
        .result2 (result2),
        .of      (of),
        .uof     (uof),
        .equal   (equal)
    );

    always #5 clk = ~clk;

    // Value of a mul/div expectation in the current build
    function automatic logic [31:0] md(input logic [31:0] v);
`ifdef ALU_MULDIV_EN
        return v;
`else
        return 32'h0 & v;
`endif
    endfunction

    // Reference model: plain 64-bit integer arithmetic on the operand values
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  input logic [3:0] op, input logic [4:0] sh,
                                  output logic [31:0] r1, output logic [31:0] r2,
                                  output logic o, output logic u, output logic e);
        longint          sa, sb, s, p, q, rm;
        longint unsigned ua, ub, us;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        r1 = 32'h0; r2 = 32'h0; o = 1'b0; u = 1'b0;
        e  = (ua == ub);
        case (op)
            4'd0:  r1 = 32'(ub << sh);
            4'd1:  r1 = 32'(sb >>> sh);
            4'd2:  r1 = 32'(ub >> sh);
            4'd3: begin
                p  = sa * sb;
                r1 = md(32'(p));
                r2 = md(32'(p >>> 32));
            end
            4'd4: begin
                if (sb == 0) begin
                    r1 = md(32'hFFFF_FFFF);
                    r2 = md(a);
                end else begin
                    q  = sa / sb;
                    rm = sa % sb;
                    r1 = md(32'(q));
                    r2 = md(32'(rm));
                end
            end
            4'd5: begin
                s  = sa + sb;
                us = ua + ub;
                r1 = 32'(us);
                o  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
                u  = (us >> 32) != 0;
            end
            4'd6: begin
                s  = sa - sb;
                r1 = 32'(ua - ub);
                o  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
                u  = ua < ub;
            end
            4'd7:  r1 = a & b;
            4'd8:  r1 = a | b;
            4'd9:  r1 = a ^ b;
            4'd10: r1 = ~(a | b);
            4'd11: r1 = (sa < sb) ? 32'd1 : 32'd0;
            4'd12: r1 = (ua < ub) ? 32'd1 : 32'd0;
            default: ;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] r1, input logic [31:0] r2,
                             input logic o, input logic u, input logic e);
        check({tag, ".result1"}, result1, r1);
        check({tag, ".result2"}, result2, r2);
        check({tag, ".of"}, {31'h0, of}, {31'h0, o});
        check({tag, ".uof"}, {31'h0, uof}, {31'h0, u});
        check({tag, ".equal"}, {31'h0, equal}, {31'h0, e});
    endtask

    // Drive on the falling edge, sample 1 time unit after the next rising edge
    task automatic drive(input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op, input logic [4:0] sh);
        @(negedge clk);
        x = a; y = b; alu_op = op; shamt = sh;
        @(posedge clk);
        #1;
    endtask

    task automatic step_exp(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] op, input logic [4:0] sh,
                            input logic [31:0] r1, input logic [31:0] r2,
                            input logic o, input logic u, input logic e);
        drive(a, b, op, sh);
        check_all(tag, r1, r2, o, u, e);
    endtask

    task automatic step_model(input string tag, input logic [31:0] a, input logic [31:0] b,
                              input logic [3:0] op, input logic [4:0] sh);
        logic [31:0] r1, r2;
        logic        o, u, e;
        model(a, b, op, sh, r1, r2, o, u, e);
        drive(a, b, op, sh);
        check_all(tag, r1, r2, o, u, e);
    endtask

    localparam logic [31:0] PX = 32'h0000_1249;
    localparam logic [31:0] PY = 32'hFFFF_FF0F;

    initial begin
        logic [31:0] a, b, r1, r2;
        logic [3:0]  op;
        logic        o, u, e;

        x = 32'd1; y = 32'd1; alu_op = ADD; shamt = 5'd0;

        // Reset asserted before any clock edge clears everything at once
        #2 rst = 1'b1;
        #1 check_all("reset_async", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1 check_all("reset_hold", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk) rst = 1'b0;
        #1 check_all("reset_release_pre_edge", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1 check_all("reset_first_op", 32'd2, 32'h0, 1'b0, 1'b0, 1'b1);

        // Plan vectors
        step_exp("sll",  PX, PY, SLL, 5'd2, 32'hFFFF_FC3C, 32'h0, 1'b0, 1'b0, 1'b0);
        step_exp("sra",  PX, PY, SRA, 5'd2, 32'hFFFF_FFC3, 32'h0, 1'b0, 1'b0, 1'b0);
        step_exp("srl",  PX, PY, SRL, 5'd2, 32'h3FFF_FFC3, 32'h0, 1'b0, 1'b0, 1'b0);
        step_exp("mul",  PX, PY, MUL, 5'd2, md(32'hFFEE_C947), md(32'hFFFF_FFFF), 1'b0, 1'b0, 1'b0);
        step_exp("div",  PX, PY, DIV, 5'd2, md(32'hFFFF_FFED), md(32'h0000_0066), 1'b0, 1'b0, 1'b0);
        step_exp("add",  PX, PY, ADD, 5'd2, 32'h0000_1158, 32'h0, 1'b0, 1'b1, 1'b0);
        step_exp("sub",  PX, PY, SUB, 5'd2, 32'h0000_133A, 32'h0, 1'b0, 1'b1, 1'b0);
        step_exp("and",  PX, PY, AND, 5'd2, 32'h0000_1209, 32'h0, 1'b0, 1'b0, 1'b0);
        step_exp("or",   PX, PY, OR,  5'd2, 32'hFFFF_FF4F, 32'h0, 1'b0, 1'b0, 1'b0);
        step_exp("xor",  PX, PY, XOR, 5'd2, 32'hFFFF_ED46, 32'h0, 1'b0, 1'b0, 1'b0);
        step_exp("nor",  PX, PY, NOR, 5'd2, 32'h0000_00B0, 32'h0, 1'b0, 1'b0, 1'b0);
        step_exp("slt",  PX, PY, SLT, 5'd2, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        step_exp("sltu", PX, PY, SLTU, 5'd2, 32'h1, 32'h0, 1'b0, 1'b0, 1'b0);
        step_exp("op13", PX, PY, 4'd13, 5'd2, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        step_exp("op14", PX, PY, 4'd14, 5'd2, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        step_exp("op15", PX, PY, 4'd15, 5'd2, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

        // Corners
        step_exp("add_ovf", 32'h7FFF_FFFF, 32'h1, ADD, 5'd0, 32'h8000_0000, 32'h0, 1'b1, 1'b0, 1'b0);
        step_exp("sub_ovf", 32'h8000_0000, 32'h1, SUB, 5'd0, 32'h7FFF_FFFF, 32'h0, 1'b1, 1'b0, 1'b0);
        step_exp("add_carry", 32'hFFFF_FFFF, 32'h1, ADD, 5'd0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        step_exp("div_zero", 32'h5, 32'h0, DIV, 5'd0, md(32'hFFFF_FFFF), md(32'h5), 1'b0, 1'b0, 1'b0);
        step_exp("div_minint", 32'h8000_0000, 32'hFFFF_FFFF, DIV, 5'd0, md(32'h8000_0000), 32'h0, 1'b0, 1'b0, 1'b0);
        step_exp("equal", 32'h7, 32'h7, AND, 5'd0, 32'h7, 32'h0, 1'b0, 1'b0, 1'b1);
        step_exp("sll_sh0", 32'h0, 32'hA5A5_0F0F, SLL, 5'd0, 32'hA5A5_0F0F, 32'h0, 1'b0, 1'b0, 1'b0);
        step_exp("sra_sh0", 32'h0, 32'h8000_0001, SRA, 5'd0, 32'h8000_0001, 32'h0, 1'b0, 1'b0, 1'b0);
        step_exp("sra_sh31", 32'h0, 32'h8000_0000, SRA, 5'd31, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 1'b0);

        // Reset asserted mid-cycle while outputs are nonzero
        step_exp("pre_mid_reset", 32'h3, 32'h3, ADD, 5'd0, 32'h6, 32'h0, 1'b0, 1'b0, 1'b1);
        #2 rst = 1'b1;
        #1 check_all("reset_mid_cycle", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk) rst = 1'b0;
        #1 check_all("reset_mid_release", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1 check_all("reset_mid_first_op", 32'h6, 32'h0, 1'b0, 1'b0, 1'b1);

        // Randomized vectors against the model
        for (int i = 0; i < 400; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            if ($urandom_range(0, 7) == 0) a = 32'h7FFF_FFFF;
            case ($urandom_range(0, 7))
                0: b = 32'h0;
                1: b = a;
                2: b = 32'hFFFF_FFFF;
                3: b = 32'($urandom_range(0, 255));
                default: ;
            endcase
            model(a, b, op, 5'($urandom_range(0, 31)), r1, r2, o, u, e);
            step_model($sformatf("rand%0d_op%0d", i, op), a, b, op, shamt_pick(i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Cycles through small, mid and edge shift amounts for the random loop
    function automatic logic [4:0] shamt_pick(input int i);
        case (i % 4)
            0:       return 5'd0;
            1:       return 5'd31;
            default: return 5'($urandom_range(0, 31));
        endcase
    endfunction

endmodule
